alu_accum_ctrl: RTL and testbench

//  Sequential issue/capture stage wrapped around the combinational Modified_ALU_Nbit.

---
 rtl/alu_accum_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_accum_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_accum_ctrl.sv
// alu_accum_ctrl: issue/capture stage wrapped around an external combinational ALU.
// Ports: cmd_* (valid/ready command in), alu_* (registered drive to and result from the ALU),
//        rsp_* (valid/ready response out); clk with synchronous active-high rst.
// Latency: EXEC_CYCLES+1 edges to rsp_valid for ALU commands, 1 edge for loads; one command in flight, no queuing.
module alu_accum_ctrl #(
  parameter int          N           = 4,
  parameter int          EXEC_CYCLES = 1,
  parameter logic [15:0] CB_MASK     = 16'h0003
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_mode,
  input  logic [N-1:0] cmd_operand,
  input  logic         cmd_load,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_mode,
  output logic         alu_cb_in,
  input  logic [N-1:0] alu_result,
  input  logic         alu_cb_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_cb,
  output logic         rsp_zero
);

  // Counter is at least one bit wide so EXEC_CYCLES=1 still elaborates cleanly.
  localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [N-1:0]       acc;
  logic               cb_flag;
  logic [CNT_W-1:0]   cnt;
  logic               cb_next;

  // The ALU sees the stored flag directly; it only changes at capture or load,
  // so it stays frozen for the whole EXEC window.
  assign alu_cb_in = cb_flag;

  // Modes with a clear mask bit leave the carry/borrow chain untouched.
  assign cb_next = CB_MASK[alu_mode] ? alu_cb_out : cb_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      cb_flag    <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_mode   <= 4'd0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cb     <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_load) begin
              // Load bypasses the ALU and clears the chain flag.
              acc        <= cmd_operand;
              cb_flag    <= 1'b0;
              rsp_result <= cmd_operand;
              rsp_cb     <= 1'b0;
              rsp_zero   <= (cmd_operand == '0);
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end else begin
              // ALU inputs are latched once here and held through EXEC.
              alu_a    <= acc;
              alu_b    <= cmd_operand;
              alu_mode <= cmd_mode;
              cnt      <= '0;
              state    <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          if (cnt == CNT_LAST) begin
            acc        <= alu_result;
            cb_flag    <= cb_next;
            rsp_result <= alu_result;
            rsp_cb     <= cb_next;
            // Same value that lands in acc, so this is the captured-result zero flag.
            rsp_zero   <= (alu_result == '0);
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// tb_alu_accum_ctrl: directed self-checking bench for alu_accum_ctrl.
// Two instances: EXEC_CYCLES=1 (main) and EXEC_CYCLES=3 (x_ prefix), each with a stub ALU.
// Stub ALU: mode 0000 A+B+CB_in, 0001 A-B-CB_in with borrow, 1111 pass B.
module tb_alu_accum_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  // main instance (EXEC_CYCLES=1)
  logic         rst, cmd_valid, cmd_ready, cmd_load, alu_cb_in, alu_cb_out;
  logic [3:0]   cmd_mode, alu_mode;
  logic [N-1:0] cmd_operand, alu_a, alu_b, alu_result, rsp_result;
  logic         rsp_valid, rsp_ready, rsp_cb, rsp_zero;

  // second instance (EXEC_CYCLES=3)
  logic         x_rst, x_cmd_valid, x_cmd_ready, x_cmd_load, x_alu_cb_in, x_alu_cb_out;
  logic [3:0]   x_cmd_mode, x_alu_mode;
  logic [N-1:0] x_cmd_operand, x_alu_a, x_alu_b, x_alu_result, x_rsp_result;
  logic         x_rsp_valid, x_rsp_ready, x_rsp_cb, x_rsp_zero;

  function automatic logic [N:0] alu_stub(input logic [3:0] m, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic ci);
    case (m)
      4'b0000: return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
      4'b0001: return {1'b0, a} - {1'b0, b} - {{N{1'b0}}, ci};
      4'b1111: return {1'b0, b};
      default: return '0;
    endcase
  endfunction

  assign {alu_cb_out, alu_result}     = alu_stub(alu_mode, alu_a, alu_b, alu_cb_in);
  assign {x_alu_cb_out, x_alu_result} = alu_stub(x_alu_mode, x_alu_a, x_alu_b, x_alu_cb_in);

  alu_accum_ctrl #(.N(N), .EXEC_CYCLES(1), .CB_MASK(16'h0003)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_operand(cmd_operand), .cmd_load(cmd_load),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_cb_in(alu_cb_in),
    .alu_result(alu_result), .alu_cb_out(alu_cb_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cb(rsp_cb), .rsp_zero(rsp_zero)
  );

  alu_accum_ctrl #(.N(N), .EXEC_CYCLES(3), .CB_MASK(16'h0003)) dut_x (
    .clk(clk), .rst(x_rst),
    .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready), .cmd_mode(x_cmd_mode),
    .cmd_operand(x_cmd_operand), .cmd_load(x_cmd_load),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_mode(x_alu_mode), .alu_cb_in(x_alu_cb_in),
    .alu_result(x_alu_result), .alu_cb_out(x_alu_cb_out),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_result(x_rsp_result),
    .rsp_cb(x_rsp_cb), .rsp_zero(x_rsp_zero)
  );

  // Issue one command on the main instance and wait (bounded) for its response.
  // lat = edge index after accept at which rsp_valid is first seen high.
  // cbi = alu_cb_in observed just after accept (inside EXEC).
  task automatic do_cmd(input logic ld, input logic [3:0] m, input logic [N-1:0] op,
                        output int lat, output logic cbi);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_mode = m; cmd_operand = op;
    while (cmd_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cbi = alu_cb_in;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic x_do_cmd(input logic ld, input logic [3:0] m, input logic [N-1:0] op,
                          output int lat);
    int w = 0;
    @(negedge clk);
    x_cmd_valid = 1'b1; x_cmd_load = ld; x_cmd_mode = m; x_cmd_operand = op;
    while (x_cmd_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    x_cmd_valid = 1'b0;
    lat = 1;
    while (x_rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic x_pop_rsp();
    x_rsp_ready = 1'b1;
    @(posedge clk); #1;
    x_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] outs;
    rst = 1'b1; x_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; x_rst = 1'b0;
    @(negedge clk);
    outs = {alu_a, alu_b, alu_mode, alu_cb_in, rsp_valid, rsp_result, rsp_cb, rsp_zero};
    cmp++; if (outs !== '0) begin err++; $display("FAIL reset_outs: got %h want 0", outs); end
    cmp++; if (cmd_ready !== 1'b1) begin err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    outs = {x_alu_a, x_alu_b, x_alu_mode, x_alu_cb_in, x_rsp_valid, x_rsp_result, x_rsp_cb, x_rsp_zero};
    cmp++; if (outs !== '0) begin err++; $display("FAIL x_reset_outs: got %h want 0", outs); end
    cmp++; if (x_cmd_ready !== 1'b1) begin err++; $display("FAIL x_reset_cmd_ready: got %b want 1", x_cmd_ready); end
  endtask

  task automatic test_chain_add();
    int lat; logic cbi;
    do_cmd(1'b1, 4'h7, 4'b1111, lat, cbi);   // load; mode is ignored
    cmp++; if (lat !== 1) begin err++; $display("FAIL load_latency: got %0d want 1", lat); end
    cmp++; if ({rsp_result, rsp_cb, rsp_zero} !== {4'b1111, 1'b0, 1'b0}) begin
      err++; $display("FAIL load_rsp: got %h/%b/%b want f/0/0", rsp_result, rsp_cb, rsp_zero); end
    pop_rsp();
    do_cmd(1'b0, 4'b0000, 4'b0001, lat, cbi); // 1111+0001+0 = 1_0000
    cmp++; if (lat !== 2) begin err++; $display("FAIL add_latency: got %0d want 2", lat); end
    cmp++; if ({rsp_valid, rsp_result, rsp_cb, rsp_zero} !== {1'b1, 4'b0000, 1'b1, 1'b1}) begin
      err++; $display("FAIL add_wrap_rsp: got v%b %h/%b/%b want v1 0/1/1", rsp_valid, rsp_result, rsp_cb, rsp_zero); end
    pop_rsp();
    do_cmd(1'b0, 4'b0000, 4'b0101, lat, cbi); // 0000+0101+1 = 0110
    cmp++; if (cbi !== 1'b1) begin err++; $display("FAIL chain_cb_in: got %b want 1", cbi); end
    cmp++; if ({alu_a, alu_b} !== {4'b0000, 4'b0101}) begin
      err++; $display("FAIL chain_alu_ab: got %h/%h want 0/5", alu_a, alu_b); end
    cmp++; if ({rsp_result, rsp_cb, rsp_zero} !== {4'b0110, 1'b0, 1'b0}) begin
      err++; $display("FAIL chain_rsp: got %h/%b/%b want 6/0/0", rsp_result, rsp_cb, rsp_zero); end
    pop_rsp();
  endtask

  task automatic test_sub_pass();
    int lat; logic cbi;
    do_cmd(1'b1, 4'b0000, 4'b0011, lat, cbi);
    pop_rsp();
    do_cmd(1'b0, 4'b0001, 4'b0101, lat, cbi); // 0011-0101 = 1110 borrow
    cmp++; if ({rsp_result, rsp_cb} !== {4'b1110, 1'b1}) begin
      err++; $display("FAIL sub_rsp: got %h/%b want e/1", rsp_result, rsp_cb); end
    pop_rsp();
    do_cmd(1'b0, 4'b1111, 4'b1010, lat, cbi); // pass B, flag untouched
    cmp++; if ({rsp_result, rsp_cb, rsp_zero} !== {4'b1010, 1'b1, 1'b0}) begin
      err++; $display("FAIL pass_rsp: got %h/%b/%b want a/1/0", rsp_result, rsp_cb, rsp_zero); end
    cmp++; if (alu_mode !== 4'b1111) begin err++; $display("FAIL pass_alu_mode: got %h want f", alu_mode); end
    pop_rsp();
  endtask

  task automatic test_backpressure();
    int lat; logic cbi;
    logic [7:0] obs;
    do_cmd(1'b0, 4'b0000, 4'b0001, lat, cbi); // 1010+0001+1 = 1100
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 4'b0000;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      obs = {rsp_valid, cmd_ready, rsp_result, rsp_cb, rsp_zero};
      cmp++; if (obs !== {1'b1, 1'b0, 4'b1100, 1'b0, 1'b0}) begin
        err++; $display("FAIL backpressure_hold[%0d]: got %b want 10110000", i, obs); end
    end
    pop_rsp();
    cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
      err++; $display("FAIL release_handshake: got %b want 01", {rsp_valid, cmd_ready}); end
    do_cmd(1'b0, 4'b0000, 4'b0000, lat, cbi); // ignored load must not have landed
    cmp++; if ({rsp_result, rsp_cb} !== {4'b1100, 1'b0}) begin
      err++; $display("FAIL ignored_load: got %h/%b want c/0", rsp_result, rsp_cb); end
    pop_rsp();
  endtask

  task automatic test_back_to_back();
    int idx[4];
    int n = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_mode = 4'b1111; cmd_operand = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready === 1'b1) begin
        if (n < 4) idx[n] = i;
        n++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmp++; if (n !== 4) begin err++; $display("FAIL b2b_count: got %0d want 4", n); end
    cmp++; if (n >= 2 && (idx[1] - idx[0]) !== 3) begin
      err++; $display("FAIL b2b_period: got %0d want 3", idx[1] - idx[0]); end
    cmp++; if ({rsp_result, rsp_valid} !== {4'b1001, 1'b0}) begin
      err++; $display("FAIL b2b_last: got %h/%b want 9/0", rsp_result, rsp_valid); end
  endtask

  task automatic test_exec3();
    int lat;
    x_do_cmd(1'b1, 4'b0000, 4'b0101, lat);
    cmp++; if (lat !== 1) begin err++; $display("FAIL x_load_latency: got %0d want 1", lat); end
    x_pop_rsp();
    x_do_cmd(1'b0, 4'b0000, 4'b0010, lat);
    cmp++; if (lat !== 4) begin err++; $display("FAIL x_exec_latency: got %0d want 4", lat); end
    cmp++; if ({x_rsp_result, x_rsp_cb} !== {4'b0111, 1'b0}) begin
      err++; $display("FAIL x_exec_rsp: got %h/%b want 7/0", x_rsp_result, x_rsp_cb); end
    x_pop_rsp();
  endtask

  task automatic test_reset_mid_exec();
    int lat;
    logic seen;
    @(negedge clk);
    x_cmd_valid = 1'b1; x_cmd_load = 1'b0; x_cmd_mode = 4'b0000; x_cmd_operand = 4'b0001;
    @(posedge clk); #1;
    x_cmd_valid = 1'b0;
    @(negedge clk);
    x_rst = 1'b1;
    @(negedge clk);
    x_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (x_rsp_valid !== 1'b0) seen = 1'b1;
    end
    cmp++; if (seen !== 1'b0) begin err++; $display("FAIL x_rst_no_rsp: got rsp_valid 1 want 0"); end
    cmp++; if (x_cmd_ready !== 1'b1) begin err++; $display("FAIL x_rst_ready: got %b want 1", x_cmd_ready); end
    x_do_cmd(1'b0, 4'b0000, 4'b0000, lat);   // acc must have been cleared
    cmp++; if ({x_alu_a, x_rsp_result, x_rsp_zero} !== {4'b0000, 4'b0000, 1'b1}) begin
      err++; $display("FAIL x_rst_acc: got a=%h res=%h z=%b want 0/0/1", x_alu_a, x_rsp_result, x_rsp_zero); end
    x_pop_rsp();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_mode = '0; cmd_operand = '0; rsp_ready = 1'b0;
    x_rst = 1'b1; x_cmd_valid = 1'b0; x_cmd_load = 1'b0; x_cmd_mode = '0; x_cmd_operand = '0; x_rsp_ready = 1'b0;
    test_reset();
    test_chain_add();
    test_sub_pass();
    test_backpressure();
    test_back_to_back();
    test_exec3();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
